// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one registered multiplier among NREQ requesters with in-order tagged results.
// Define MULT_ARB_RR_EN for round-robin arbitration; otherwise the lowest requester index wins.
module mult_arbiter #(
  parameter int N = 8,
  parameter int NREQ = 4,
  parameter int LAT = 2,
  parameter int DEPTH = 4,
  localparam int IW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              mul_ea,
  output logic              mul_eb,
  output logic [N-1:0]      mul_a,
  output logic [N-1:0]      mul_b,
  input  logic [2*N-1:0]    mul_p,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [2*N-1:0]    rsp_p,
  output logic [IW-1:0]     rsp_id,
  output logic              busy
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + LAT + 1);
  logic [IW-1:0] start, gid, k;
  logic [NREQ-1:0] gnt;
  logic issue, permit, push, pop;
  logic [CW-1:0] outst, count;
  logic [LAT-1:0] tag_v;
  logic [IW-1:0] tag_id [LAT];
  logic [2*N-1:0] mem_p [DEPTH];
  logic [IW-1:0] mem_id [DEPTH];
  logic [PW-1:0] wptr, rptr;
`ifdef MULT_ARB_RR_EN
  always_ff @(posedge clk)
    if (rst) start <= '0;
    else if (issue) start <= (int'(gid) == NREQ - 1) ? '0 : gid + 1'b1;
`else
  assign start = '0;
`endif
  // credits cover both tags still inside the multiplier and buffered results
  always_comb begin
    outst = count;
    for (int i = 0; i < LAT; i++) outst = outst + CW'(tag_v[i]);
  end
  assign permit = !rst && outst < CW'(DEPTH);
  // walk from the far end back toward start so the candidate nearest start wins
  always_comb begin
    gnt = '0;
    gid = '0;
    k = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = IW'((int'(start) + i) % NREQ);
      if (req_valid[k]) begin
        gid = k;
        gnt = NREQ'(1) << k;
      end
    end
  end
  assign issue = permit && |req_valid;
  assign req_ready = issue ? gnt : '0;
  assign mul_ea = issue;
  assign mul_eb = issue;
  assign mul_a = req_a[int'(gid)*N +: N];
  assign mul_b = req_b[int'(gid)*N +: N];
  always_ff @(posedge clk) begin
    tag_v <= rst ? '0 : LAT'({tag_v, issue});
    tag_id[0] <= gid;
    for (int i = 1; i < LAT; i++) tag_id[i] <= tag_id[i-1];
  end
  assign push = tag_v[LAT-1];
  assign pop = rsp_valid && rsp_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem_p[wptr] <= mul_p;
        mem_id[wptr] <= tag_id[LAT-1];
        wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
      end
      if (pop) rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assign rsp_valid = count != '0;
  assign rsp_p = mem_p[rptr];
  assign rsp_id = mem_id[rptr];
  assign busy = |tag_v || rsp_valid;
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && !pop && count == CW'(DEPTH)));
  a_onehot: assert property (@(posedge clk) $onehot0(req_ready));
endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: randomized and directed bench for mult_arbiter against a queue-based model.
module tb_mult_arbiter;
  localparam int N = 8, NREQ = 4, LAT = 2, DEPTH = 4, IW = 2;
`ifdef MULT_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [NREQ-1:0] req_valid = '0, req_ready;
  logic [NREQ*N-1:0] req_a = '0, req_b = '0;
  logic mul_ea, mul_eb, rsp_valid, busy, rsp_ready = 1'b1;
  logic [N-1:0] mul_a, mul_b, ra, rb;
  logic [2*N-1:0] mul_p, rsp_p;
  logic [IW-1:0] rsp_id;
  int nchk = 0, nerr = 0;
  always #5 clk = ~clk;
  mult_arbiter #(.N(N), .NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mul_ea(mul_ea), .mul_eb(mul_eb), .mul_a(mul_a), .mul_b(mul_b),
    .mul_p(mul_p), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_p(rsp_p),
    .rsp_id(rsp_id), .busy(busy));
  // the shared registered multiplier: operand regs gated by E_a/E_b, then a product register
  always @(posedge clk) begin
    if (mul_ea) ra <= mul_a;
    if (mul_eb) rb <= mul_b;
    mul_p <= 16'(ra) * 16'(rb);
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // model: every granted op is one queue entry until popped; it becomes visible LAT+1 cycles after grant
  typedef struct { int id; int p; int rdy; } op_t;
  op_t q[$];
  int ptr = 0, cyc = 0;
  always @(negedge clk) begin
    int eg, kk;
    logic erv;
    cyc++;
    eg = -1;
    erv = 1'b0;
    if (!rst && q.size() < DEPTH)
      for (int i = 0; i < NREQ; i++) begin
        kk = (ptr + i) % NREQ;
        if (eg < 0 && req_valid[kk[IW-1:0]]) eg = kk;
      end
    check("req_ready", 32'(req_ready), eg < 0 ? 32'd0 : 32'd1 << eg);
    check("mul_ea", 32'(mul_ea), 32'(eg >= 0));
    check("mul_eb", 32'(mul_eb), 32'(eg >= 0));
    if (eg >= 0) begin
      check("mul_a", 32'(mul_a), 32'(req_a[eg*N +: N]));
      check("mul_b", 32'(mul_b), 32'(req_b[eg*N +: N]));
    end
    if (!rst) begin
      erv = q.size() > 0 && q[0].rdy <= cyc;
      check("rsp_valid", 32'(rsp_valid), 32'(erv));
      check("busy", 32'(busy), 32'(q.size() > 0));
      if (erv) begin
        check("rsp_p", 32'(rsp_p), q[0].p);
        check("rsp_id", 32'(rsp_id), q[0].id);
      end
    end
    if (rst) begin
      q.delete();
      ptr = 0;
    end else begin
      if (erv && rsp_ready) void'(q.pop_front());
      if (eg >= 0) begin
        q.push_back('{eg, int'(req_a[eg*N +: N]) * int'(req_b[eg*N +: N]), cyc + LAT + 1});
        if (RR) ptr = (eg + 1) % NREQ;
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  task automatic set_req(input int k, input int a, input int b);
    req_valid = NREQ'(1) << k;
    req_a[k*N +: N] = N'(a);
    req_b[k*N +: N] = N'(b);
  endtask
  task automatic one_op(input int k, input int a, input int b, input int exp_p);
    int n;
    tick();
    set_req(k, a, b);
    @(negedge clk);
    check("op_grant", 32'(req_ready), 32'd1 << k);
    check("op_ea", 32'(mul_ea), 32'd1);
    tick();
    req_valid = '0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 10);
    check("op_rsp_seen", 32'(rsp_valid), 32'd1);
    check("op_latency", n, 32'd3);
    check("op_rsp_p", 32'(rsp_p), exp_p);
    check("op_rsp_id", 32'(rsp_id), k);
    @(negedge clk);
    check("op_busy_clear", 32'(busy), 32'd0);
  endtask
  initial begin
    int gi;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    one_op(1, 3, 5, 15);
    one_op(2, 255, 255, 'hFE01);
    one_op(0, 0, 200, 0);
    one_op(3, 1, 255, 255);
    one_op(1, 128, 2, 256);
    do_reset();
    req_valid = '1;
    for (int i = 0; i < 8; i++) begin
      req_a = $urandom;
      req_b = $urandom;
      @(negedge clk);
      gi = -1;
      for (int j = 0; j < NREQ; j++) if (req_ready[j]) gi = j;
      check("stream_grant", gi, RR ? i % NREQ : 0);
      tick();
    end
    req_valid = '0;
    repeat (8) tick();
    rsp_ready = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      set_req(k, $urandom_range(0, 255), $urandom_range(0, 255));
      @(negedge clk);
      check("fill_grant", 32'(req_ready), 32'd1 << k);
      tick();
    end
    req_valid = '1;
    repeat (4) begin
      @(negedge clk);
      check("full_stall", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("pop_cycle_stall", 32'(req_ready), 32'd0);
    check("first_pop_id", 32'(rsp_id), 32'd0);
    tick();
    @(negedge clk);
    check("resume_after_pop", 32'(req_ready != 0), 32'd1);
    tick();
    req_valid = '0;
    repeat (10) tick();
    set_req(0, 10, 10);
    tick();
    set_req(1, 20, 20);
    tick();
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("midrst_no_stale", 32'(rsp_valid), 32'd0);
    end
    one_op(2, 7, 9, 63);
    for (int i = 0; i < 10000; i++) begin
      tick();
      req_valid = NREQ'($urandom);
      req_a = $urandom;
      req_b = $urandom;
      if ($urandom_range(0, 7) == 0) req_a = '1;
      if ($urandom_range(0, 7) == 0) req_b = '0;
      rsp_ready = $urandom_range(0, 3) != 0;
    end
    tick();
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (12) tick();
    @(negedge clk);
    check("drain_busy", 32'(busy), 32'd0);
    check("drain_model_empty", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
